// File: rtl/display_pkg.sv
// Shared types and constants for the OUT-port decimal display.
// Digit codes: 0-9 are decimal digits, DIG_MINUS is the sign, DIG_BLANK is an unlit digit.
package display_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StCommit
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t DIG_MINUS = 4'hA;
    localparam digit_t DIG_BLANK = 4'hF;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/output_display_if.sv
// Capture-side and display-side signals of the OUT-port display.
// master drives the capture strobe and data bus; slave is the display block.
interface output_display_if;
    logic       out_en;
    logic [7:0] bus;
    logic       signed_mode;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;
    logic [7:0] value;

    modport master (
        output out_en, bus, signed_mode,
        input  seg, an, dp, busy, value
    );

    modport slave (
        input  out_en, bus, signed_mode,
        output seg, an, dp, busy, value
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low seven-segment pattern decoder.
// Codes with no assigned glyph render as blank.
module seg7_decode
    import display_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            4'd8:      seg = SEG_8;
            4'd9:      seg = SEG_9;
            DIG_MINUS: seg = SEG_MINUS;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/output_display.sv
// Captures OUT values, converts them to decimal by double-dabble and drives a
// 4-digit multiplexed seven-segment display that only changes on a completed conversion.
module output_display
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    output_display_if.slave dif
);

    localparam int unsigned CntW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

    state_t      state_q, state_d;
    logic        busy;
    logic [7:0]  value_q;
    logic        neg_q;
    logic [19:0] shreg_q, shreg_next, adj;
    logic [2:0]  iter_q;
    logic        pend_valid_q, pend_mode_q;
    logic [7:0]  pend_bus_q;
    digit_t      digit_q [4];
    digit_t      commit_dig [4];

    logic        load, load_mode, load_neg;
    logic [7:0]  load_bus, load_mag;

    logic [CntW-1:0] refresh_q;
    logic [1:0]      index_q;
    logic [6:0]      seg_q, seg_dec;
    logic [3:0]      an_q;

    // A strobe on the commit edge beats the pending slot.
    always_comb begin
        load      = 1'b0;
        load_bus  = dif.bus;
        load_mode = dif.signed_mode;
        unique case (state_q)
            StIdle: load = dif.out_en;
            StCommit: begin
                if (dif.out_en) begin
                    load = 1'b1;
                end else if (pend_valid_q) begin
                    load      = 1'b1;
                    load_bus  = pend_bus_q;
                    load_mode = pend_mode_q;
                end
            end
            default: load = 1'b0;
        endcase
    end

    // Low 8 bits of the 9-bit negate, so 0x80 yields magnitude 128.
    assign load_neg = load_mode & load_bus[7];
    assign load_mag = load_neg ? (~load_bus + 8'd1) : load_bus;

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (load) state_d = StConvert;
            StConvert: if (iter_q == 3'd7) state_d = StCommit;
            StCommit:  state_d = load ? StConvert : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_comb begin
        adj = shreg_q;
        for (int i = 0; i < 3; i++) begin
            if (adj[8+4*i +: 4] >= 4'd5) adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
        end
        shreg_next = {adj[18:0], 1'b0};
    end

    // Leading-zero blanking; the ones digit is always lit.
    always_comb begin
        commit_dig[0] = shreg_q[11:8];
        commit_dig[1] = (shreg_q[19:16] != 4'd0 || shreg_q[15:12] != 4'd0) ? shreg_q[15:12]
                                                                           : DIG_BLANK;
        commit_dig[2] = (shreg_q[19:16] != 4'd0) ? shreg_q[19:16] : DIG_BLANK;
        commit_dig[3] = neg_q ? DIG_MINUS : DIG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q      <= 8'd0;
            neg_q        <= 1'b0;
            shreg_q      <= 20'd0;
            iter_q       <= 3'd0;
            pend_valid_q <= 1'b0;
            pend_bus_q   <= 8'd0;
            pend_mode_q  <= 1'b0;
            for (int i = 0; i < 4; i++) digit_q[i] <= DIG_BLANK;
        end else begin
            if (load) begin
                value_q <= load_bus;
                neg_q   <= load_neg;
                shreg_q <= {12'd0, load_mag};
                iter_q  <= 3'd0;
            end else if (state_q == StConvert) begin
                shreg_q <= shreg_next;
                iter_q  <= iter_q + 3'd1;
            end
            if (state_q == StCommit) begin
                for (int i = 0; i < 4; i++) digit_q[i] <= commit_dig[i];
            end
            if (state_q == StConvert && dif.out_en) begin
                pend_valid_q <= 1'b1;
                pend_bus_q   <= dif.bus;
                pend_mode_q  <= dif.signed_mode;
            end else if (state_q == StCommit) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    seg7_decode u_seg7_decode (
        .digit(digit_q[index_q]),
        .seg  (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            index_q   <= 2'd0;
            seg_q     <= SEG_BLANK;
            an_q      <= 4'hF;
        end else begin
            if (refresh_q == CntW'(REFRESH_CYCLES - 1)) begin
                refresh_q <= '0;
                index_q   <= index_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + 1'b1;
            end
            seg_q <= seg_dec;
            an_q  <= ~(4'b0001 << index_q);
        end
    end

    assign dif.seg   = seg_q;
    assign dif.an    = an_q;
    assign dif.dp    = 1'b1;
    assign dif.busy  = busy;
    assign dif.value = value_q;

endmodule

// File: tb/tb_output_display.sv
// Randomised and directed bench for output_display, checked against an
// arithmetic model of the decimal rendering and the capture/commit timeline.
module tb_output_display;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    output_display_if dif ();

    output_display #(.REFRESH_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .dif(dif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_pat(input logic [3:0] code);
        case (code)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'hA:    return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Packed {d3,d2,d1,d0} from plain decimal arithmetic.
    function automatic logic [15:0] model_disp(input logic [7:0] b, input logic s);
        int v, m, h, t, o;
        logic [15:0] d;
        v = s ? int'($signed(b)) : int'(b);
        m = (v < 0) ? -v : v;
        h = m / 100;
        t = (m / 10) % 10;
        o = m % 10;
        d[3:0]   = 4'(o);
        d[7:4]   = (m >= 10)  ? 4'(t) : 4'hF;
        d[11:8]  = (m >= 100) ? 4'(h) : 4'hF;
        d[15:12] = (v < 0)    ? 4'hA  : 4'hF;
        return d;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] d, input logic [3:0] an);
        case (an)
            4'b1110: return seg_pat(d[3:0]);
            4'b1101: return seg_pat(d[7:4]);
            4'b1011: return seg_pat(d[11:8]);
            4'b0111: return seg_pat(d[15:12]);
            default: return 7'h7F;
        endcase
    endfunction

    task automatic sample_scan(input string tag, input logic [15:0] d);
        check({tag, "_an"}, 32'(dif.an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}), 32'd1);
        check({tag, "_seg"}, 32'(dif.seg), 32'(exp_seg(d, dif.an)));
    endtask

    task automatic check_scan(input string tag, input logic [15:0] d, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            sample_scan(tag, d);
        end
    endtask

    // Leaves the bench at the negedge after the commit edge.
    task automatic run_case(input string tag, input logic [7:0] b, input logic s);
        int busy_cycles;
        @(negedge clk);
        dif.out_en = 1'b1;
        dif.bus = b;
        dif.signed_mode = s;
        @(negedge clk);
        dif.out_en = 1'b0;
        busy_cycles = 0;
        while (dif.busy && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd9);
        check({tag, "_value"}, 32'(dif.value), 32'(b));
        check_scan(tag, model_disp(b, s), 16);
    endtask

    // v0 strobed for E0, v1 for E(k1), v2 for E(k2); v2 is the one converted second.
    task automatic two_conv(input string tag, input logic [7:0] v0, input logic [7:0] v1,
                            input int k1, input logic [7:0] v2, input int k2);
        @(negedge clk);
        dif.out_en = 1'b1;
        dif.bus = v0;
        dif.signed_mode = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 18) check({tag, "_busy"}, 32'(dif.busy), 32'd1);
            if (k == 19) check({tag, "_idle"}, 32'(dif.busy), 32'd0);
            if (k <= 9)  check({tag, "_value0"}, 32'(dif.value), 32'(v0));
            else         check({tag, "_value1"}, 32'(dif.value), 32'(v2));
            if (k >= 11 && k <= 19) sample_scan({tag, "_first"}, model_disp(v0, 1'b0));
            if (k >= 20) sample_scan({tag, "_second"}, model_disp(v2, 1'b0));
            dif.out_en = (k == k1) || (k == k2);
            dif.bus = (k == k1) ? v1 : v2;
        end
    endtask

    initial begin
        rst = 1'b1;
        dif.out_en = 1'b0;
        dif.bus = 8'd0;
        dif.signed_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_seg", 32'(dif.seg), 32'h7F);
        check("rst_an", 32'(dif.an), 32'hF);
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_dp", 32'(dif.dp), 32'd1);
        check("rst_value", 32'(dif.value), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] e;
            @(negedge clk);
            e = 4'b1111 ^ (4'b0001 << (k / 4));
            check("post_rst_an", 32'(dif.an), 32'(e));
            check("post_rst_seg", 32'(dif.seg), 32'h7F);
            check("post_rst_dp", 32'(dif.dp), 32'd1);
        end

        run_case("u123", 8'd123, 1'b0);
        run_case("s_f6", 8'hF6, 1'b1);
        run_case("s_80", 8'h80, 1'b1);
        run_case("u_80", 8'h80, 1'b0);
        run_case("zero", 8'd0, 1'b0);

        two_conv("b2b", 8'd5, 8'd7, 1, 8'd9, 2);
        two_conv("commit_edge", 8'd11, 8'd22, 3, 8'd33, 9);

        @(negedge clk);
        dif.out_en = 1'b1;
        dif.bus = 8'd200;
        dif.signed_mode = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) dif.out_en = 1'b0;
            if (k == 4) begin
                check("midrst_busy_before", 32'(dif.busy), 32'd1);
                rst = 1'b1;
            end
            if (k == 5) begin
                check("midrst_busy", 32'(dif.busy), 32'd0);
                check("midrst_an", 32'(dif.an), 32'hF);
                check("midrst_seg", 32'(dif.seg), 32'h7F);
                rst = 1'b0;
            end
        end
        check_scan("midrst_blank", 16'hFFFF, 16);
        run_case("after_rst_42", 8'd42, 1'b0);

        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            logic s;
            b = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            run_case($sformatf("rand%0d_%0h_%0d", i, b, s), b, s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
